// File: rtl/up_counter.sv
// Modulo-2^WIDTH up counter advanced by an internal clock-enable prescaler.
// Provides the count value, a per-step strobe (tick) and a wrap strobe (tc).
module up_counter #(
  parameter int WIDTH = 4,
  parameter int DIV   = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc
);

  localparam int               DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [WIDTH-1:0] MAX      = '1;

  logic [DIV_W-1:0] div_cnt;

  // With DIV=1, DIV_LAST is 0 and every enabled cycle takes the step branch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      count   <= '0;
      tick    <= 1'b0;
      tc      <= 1'b0;
    end else if (clr) begin
      div_cnt <= '0;
      count   <= '0;
      tick    <= 1'b0;
      tc      <= 1'b0;
    end else if (load) begin
      div_cnt <= '0;
      count   <= load_val;
      tick    <= 1'b0;
      tc      <= 1'b0;
    end else if (!en) begin
      tick <= 1'b0;
      tc   <= 1'b0;
    end else if (div_cnt != DIV_LAST) begin
      div_cnt <= div_cnt + DIV_W'(1);
      tick    <= 1'b0;
      tc      <= 1'b0;
    end else begin
      div_cnt <= '0;
      count   <= count + WIDTH'(1);
      tick    <= 1'b1;
      tc      <= (count == MAX);
    end
  end

endmodule

// File: doc/up_counter.md
# up_counter

Free-running modulo-2^WIDTH up counter with an integrated clock-enable prescaler. It counts in the opposite direction to the team's existing down counter: 0, 1, 2 … MAX, then wraps to 0. Unlike that counter, it runs entirely on the single system clock and advances on a one-cycle enable pulse, not on a divided clock. It feeds the lab display and sequencing logic with a count value, a per-step strobe and a wrap strobe.

## Interface
- WIDTH, 4, count width in bits; MAX = 2^WIDTH-1.
- DIV, 50000000, system-clock cycles per count step; legal range is DIV >= 1.
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset; clears all state immediately when low.
- en  input  1  run enable; when low, the prescaler and the count freeze.
- clr  input  1  synchronous clear of the count and the prescaler.
- load  input  1  synchronous load of load_val into the count.
- load_val  input  WIDTH  value to load.
- count  output  WIDTH  current count, registered.
- tick  output  1  one-cycle strobe, registered; high in the cycle after each count step.
- tc  output  1  one-cycle terminal-count strobe, registered; high in the cycle after a MAX->0 wrap.

## Operation
- Internal state: div_cnt, range 0..DIV-1, width ceil(log2(DIV)) with a minimum of 1; count; tick; tc.
- Reset (rst=0), asynchronous: div_cnt=0, count=0, tick=0, tc=0. The reset holds for as long as rst stays low.
- Each rising edge with rst=1 takes the first matching case, in this priority order:
  - clr=1: div_cnt<=0, count<=0, tick<=0, tc<=0. en and load are ignored.
  - load=1: count<=load_val, div_cnt<=0, tick<=0, tc<=0.
  - en=0: div_cnt and count hold; tick<=0, tc<=0.
  - en=1 and div_cnt<DIV-1: div_cnt<=div_cnt+1; tick<=0, tc<=0.
  - en=1 and div_cnt==DIV-1: div_cnt<=0, count<=count+1 mod 2^WIDTH, tick<=1, tc<=(count==MAX).
- Arithmetic: count is unsigned and wraps silently from MAX to 0. No saturation, no overflow flag beyond tc.
- DIV=1: div_cnt is constantly 0. count steps on every enabled cycle and tick stays high continuously while en=1.
- Loading MAX: tc fires on the next step, when count wraps to 0.
- Dropping en mid-period preserves div_cnt, so the partial period resumes where it stopped when en returns.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Step latency from the first enabled cycle after reset, clr or load: count changes on the DIV-th enabled rising edge, and tick is high during the cycle that follows that edge.
- tick and tc are exactly one cycle wide for DIV>=2. tc is always coincident with a tick.
- clr and load take effect at the next rising edge; count shows the new value in the following cycle.
- If rst is asserted mid-period, the partial prescale is lost; after rst is released, a full DIV enabled cycles pass before the first step.
- Simultaneous clr and load: clr wins, count=0. Simultaneous load and a step: the load wins, the step is lost, and no tick is produced.

## Test plan
- Reset/basic count, WIDTH=4, DIV=4: hold rst=0, check count=0, tick=0, tc=0; release, en=1 -> count reads 1 after 4 edges, 2 after 8, and tick is high for one cycle every 4 cycles.
- Wrap: DIV=4, run 64 enabled cycles from 0 -> count sequence 0..15 then 0; tc is high for exactly one cycle, coincident with the tick where count becomes 0.
- Pause: DIV=4, en=1 for 2 cycles, en=0 for 10, en=1 again -> count steps to 1 after 2 more enabled cycles; no tick while en=0.
- Load/clear priority: load=1, load_val=15 -> count=15 and div_cnt restarts; after 4 enabled cycles count=0 and tc=1. Assert clr and load together with load_val=9 -> count=0.
- DIV=1: en=1 for 20 cycles -> count increments every cycle, tick stays high, and tc pulses at each 15->0 transition.
- Async reset mid-period: DIV=4, count=7, div_cnt=2; pull rst low between clock edges -> count=0 immediately without a clock edge; after release, the first step comes 4 enabled edges later.
